// File: rtl/multicycle_latch_bank.sv
// Parametrised bank of inter-stage datapath registers with per-channel valid and saturating age.
// Optional macro LATCH_BANK_BYPASS_EN forwards din to dout combinationally on a live write.
module multicycle_latch_bank #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned AGE_W      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH*DATA_WIDTH-1:0] din,
  input  logic [NUM_CH-1:0]            wr_en,
  input  logic                         hold,
  input  logic                         flush,
  output logic [NUM_CH*DATA_WIDTH-1:0] dout,
  output logic [NUM_CH-1:0]            valid,
  output logic [NUM_CH*AGE_W-1:0]      age
);

  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic [AGE_W-1:0]      age_q;

    // Priority: reset > flush > hold > write; age counts only once a channel holds data.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        data_q  <= '0;
        valid_q <= 1'b0;
        age_q   <= '0;
      end else if (flush) begin
        data_q  <= '0;
        valid_q <= 1'b0;
        age_q   <= '0;
      end else if (!hold) begin
        if (wr_en[i]) begin
          data_q  <= din[i*DATA_WIDTH +: DATA_WIDTH];
          valid_q <= 1'b1;
          age_q   <= '0;
        end else if (valid_q && (age_q != AGE_MAX)) begin
          age_q <= age_q + AGE_W'(1);
        end
      end
    end

    assign age[i*AGE_W +: AGE_W] = age_q;

`ifdef LATCH_BANK_BYPASS_EN
    logic bypass_c;
    assign bypass_c = wr_en[i] & ~hold & ~flush & ~reset;
    assign dout[i*DATA_WIDTH +: DATA_WIDTH] = bypass_c ? din[i*DATA_WIDTH +: DATA_WIDTH] : data_q;
    assign valid[i] = valid_q | bypass_c;
`else
    assign dout[i*DATA_WIDTH +: DATA_WIDTH] = data_q;
    assign valid[i] = valid_q;
`endif
  end

endmodule

// File: tb/tb_multicycle_latch_bank.sv
// Randomised and directed bench for multicycle_latch_bank against a per-channel behavioural model.
// Expectations follow LATCH_BANK_BYPASS_EN when it is defined for the build.
module tb_multicycle_latch_bank;

  localparam int unsigned DW  = 32;
  localparam int unsigned NCH = 2;
  localparam int unsigned AW  = 4;
  localparam int unsigned AGE_SAT = (1 << AW) - 1;

  logic                clk;
  logic                reset;
  logic [NCH*DW-1:0]   din;
  logic [NCH-1:0]      wr_en;
  logic                hold;
  logic                flush;
  logic [NCH*DW-1:0]   dout;
  logic [NCH-1:0]      valid;
  logic [NCH*AW-1:0]   age;

  int errors = 0;
  int checks = 0;

  // Behavioural model: one record per channel
  logic [DW-1:0] m_data  [NCH];
  bit            m_valid [NCH];
  int unsigned   m_age   [NCH];

  multicycle_latch_bank #(.DATA_WIDTH(DW), .NUM_CH(NCH), .AGE_W(AW)) dut (
    .clk(clk), .reset(reset), .din(din), .wr_en(wr_en), .hold(hold),
    .flush(flush), .dout(dout), .valid(valid), .age(age)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) begin
      m_data[i] = '0; m_valid[i] = 0; m_age[i] = 0;
    end
  endtask

  // What the bank should hold after the coming rising edge, from the current inputs
  task automatic model_edge();
    if (reset || flush) begin
      model_clear();
    end else if (!hold) begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_en[i]) begin
          m_data[i] = din[i*DW +: DW]; m_valid[i] = 1; m_age[i] = 0;
        end else if (m_valid[i]) begin
          m_age[i] = (m_age[i] < AGE_SAT) ? m_age[i] + 1 : AGE_SAT;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [DW-1:0] exp_d;
    bit exp_v;
    for (int i = 0; i < NCH; i++) begin
      exp_d = m_data[i];
      exp_v = m_valid[i];
`ifdef LATCH_BANK_BYPASS_EN
      if (wr_en[i] && !hold && !flush && !reset) begin
        exp_d = din[i*DW +: DW];
        exp_v = 1;
      end
`endif
      check($sformatf("%s.dout%0d", tag, i), dout[i*DW +: DW], exp_d);
      check($sformatf("%s.valid%0d", tag, i), 32'(valid[i]), 32'(exp_v));
      check($sformatf("%s.age%0d", tag, i), 32'(age[i*AW +: AW]), m_age[i]);
    end
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    wr_en = '0; hold = 1'b0; flush = 1'b0;
  endtask

  // Assert reset between edges and expect the cleared state before any clock edge
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    check_all(tag);
    step({tag, "_edge"});
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; din = '0; idle();
    model_clear();
    #2;
    check_all("rst_init");
    step("rst_hold");
    reset = 1'b0;

    // Independent write on channel 0 only
    din = {32'hDEADBEEF, 32'h12345678};
    wr_en = 2'b01;
    step("wr_ch0");
    check("wr_ch0.exact", dout[31:0], 32'h12345678);
    check("wr_ch1.zero", dout[63:32], 32'h0);
    idle();

    // Aging and saturation
    for (int k = 0; k < 20; k++) step($sformatf("age%0d", k));
    check("age_sat", 32'(age[AW-1:0]), 32'd15);
    check("age1_zero", 32'(age[2*AW-1:AW]), 32'd0);

    // Hold swallows a write, and releasing hold does not replay it
    din = {2{32'hAAAAAAAA}};
    hold = 1'b1; wr_en = 2'b11;
    step("hold_wr");
    check("hold_keep", dout[31:0], 32'h12345678);
    idle();
    step("hold_rel");
    check("hold_lost", dout[63:32], 32'h0);

    // Write ch1 then flush with hold and write pending
    wr_en = 2'b10; din = {32'h11112222, 32'h0};
    step("wr_ch1");
    flush = 1'b1; hold = 1'b1; wr_en = 2'b11; din = {2{32'h55555555}};
    step("flush_pri");
    check("flush_valid", 32'(valid), 32'd0);
    idle();

    // Bypass window: before the edge, old or forwarded value depending on build
    wr_en = 2'b01; din = {32'h0, 32'h00000BAD};
    step("pre_byp");
    idle(); step("pre_byp_idle");
    wr_en = 2'b10; din = {32'h0000CAFE, 32'hFFFFFFFF};
    #1;
    check_all("byp_before_edge");
`ifdef LATCH_BANK_BYPASS_EN
    check("byp_ch1", dout[63:32], 32'h0000CAFE);
`else
    check("nobyp_ch1", dout[63:32], 32'h0);
`endif
    step("byp_edge");
    check("byp_after", dout[63:32], 32'h0000CAFE);
    idle();

    // Writes then asynchronous reset
    wr_en = 2'b11; din = {32'hCAFEF00D, 32'hBEEFBEEF};
    step("pre_rst");
    idle(); step("pre_rst_idle");
    async_reset("async_rst");

    // Randomised traffic
    for (int k = 0; k < 400; k++) begin
      din   = {$urandom, $urandom};
      wr_en = NCH'($urandom);
      hold  = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) wr_en = '0;
      if ($urandom_range(0, 99) == 0) begin
        idle();
        async_reset($sformatf("rnd_rst%0d", k));
      end else begin
        #1;
        check_all($sformatf("rnd_pre%0d", k));
        step($sformatf("rnd%0d", k));
      end
      if (k % 50 == 0) begin
        idle();
        for (int j = 0; j < 18; j++) step($sformatf("rnd_idle%0d_%0d", k, j));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_latch_bank.md
Name: multicycle_latch_bank

Overview:
Parametrised bank of NUM_CH inter-stage datapath registers for the multicycle CPU. It generalises the fixed A/B operand latches to any count and width of latches (A, B, IR, MDR, ALUOut, ...). Each channel has its own write enable, valid flag and saturating age counter. Global hold (stall) and flush controls apply to the whole bank. The block sits between register-file/memory read and the ALU/writeback stages, and its outputs are truly registered.

Parameters:
DATA_WIDTH, 32, width of each channel in bits (>=1)
NUM_CH, 2, number of independent channels (>=1)
AGE_W, 4, width of each per-channel age counter (>=1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
din  input  NUM_CH*DATA_WIDTH  packed write data; channel i at [i*DATA_WIDTH +: DATA_WIDTH]
wr_en  input  NUM_CH  per-channel capture enable; bit i selects channel i
hold  input  1  global stall; freezes all state
flush  input  1  synchronous global clear
dout  output  NUM_CH*DATA_WIDTH  packed registered data, same packing as din
valid  output  NUM_CH  channel written since last reset/flush
age  output  NUM_CH*AGE_W  cycles since last write per channel, saturating; channel i at [i*AGE_W +: AGE_W]

Behaviour:
- Reset is asynchronous and active-high. While reset=1: dout=0, valid=0, age=0 immediately, independent of clk.
- All other updates occur on the rising edge of clk. Priority at each edge: reset > flush > hold > wr_en.
- flush=1: all dout<=0, valid<=0, age<=0, regardless of hold and wr_en.
- hold=1 (flush=0): dout, valid and age all keep their values. wr_en is ignored, and age does not count.
- Normal edge (flush=0, hold=0), per channel i:
  - wr_en[i]=1: dout_i<=din_i, valid[i]<=1, age_i<=0.
  - wr_en[i]=0 and valid[i]=1: dout_i is kept; age_i<=age_i+1, saturating at 2^AGE_W-1 (no wrap).
  - wr_en[i]=0 and valid[i]=0: dout_i is kept; age_i stays 0.
- Channels are fully independent. Any subset of wr_en bits may be set in the same cycle.
- Capture latency is 1 cycle: din sampled at edge k appears on dout after edge k.
- Without the optional feature, outputs depend only on state; there is no combinational path from din, wr_en, hold or flush.
- If reset deasserts mid-sequence, the bank resumes from the all-zero state on the next edge. No partial writes are retained.
- Simultaneous wr_en and flush: flush wins, so dout=0 and valid=0.
- Simultaneous wr_en and hold: hold wins, and the write is lost. The controller must reassert wr_en.

Optional Feature:
Macro LATCH_BANK_BYPASS_EN.
- Defined: when wr_en[i]=1, hold=0, flush=0 and reset=0, dout_i shows din_i combinationally in the same cycle, and valid[i] reads 1. The state update at the edge is unchanged. age is never bypassed.
- Undefined: outputs are purely registered, as described in Behaviour.

Test Plan:
- Reset check, params 32/2/4: assert reset asynchronously mid-cycle after writes -> dout=0, valid=2'b00, age=0 immediately, with no clk edge needed.
- Independent write: wr_en=2'b01, din={32'hDEADBEEF,32'h12345678}, one edge -> ch0=32'h12345678, ch1=0, valid=2'b01, age0=0.
- Aging and saturation: after the ch0 write, 20 idle edges -> age0 reaches 15 and stays 15, age1 stays 0, ch0 unchanged.
- Hold vs write: hold=1, wr_en=2'b11, din=all 32'hAAAAAAAA -> dout, valid and age unchanged. Release hold with wr_en=0 -> the data is still not captured.
- Flush priority: flush=1, hold=1, wr_en=2'b11 -> after the edge dout=0, valid=0, age=0.
- Bypass (only with LATCH_BANK_BYPASS_EN): wr_en=2'b10, din ch1=32'h0000CAFE -> dout ch1=32'h0000CAFE before the edge. The same test without the macro -> the old value is shown until the edge.
